// File: rtl/fpalu_pkg.sv
// Shared types and constants for the fpalu3 add/subtract path.
package fpalu_pkg;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   mant;
    } fp_op_t;
endpackage

// File: rtl/fpalu_unpack.sv
// Splits an IEEE-754 single into sign/exponent/24b mantissa; denormals flush to zero.
module fpalu_unpack
    import fpalu_pkg::*;
(
    input  logic [31:0] i_word,
    output fp_op_t      o_op,
    output logic        o_exc
);
    logic [EXP_W-1:0] w_exp;

    assign w_exp = i_word[30:23];
    assign o_exc = (w_exp == EXP_MAX);

    always_comb begin
        o_op.sign = i_word[31];
        o_op.exp  = w_exp;
        o_op.mant = (w_exp == '0) ? '0 : {1'b1, i_word[MAN_W-1:0]};
    end
endmodule

// File: rtl/fpadd_seq_ctrl.sv
// Multi-cycle FP add/sub sequencer: one-bit-per-cycle align and normalize, truncating.
module fpadd_seq_ctrl
    import fpalu_pkg::*;
#(
    parameter int MAX_ALIGN = MAN_W + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        exc,
    output logic        busy
);
    localparam int MW    = MAN_W + 1;
    localparam int CNT_W = $clog2(MAX_ALIGN + 1);

    fp_op_t w_ua, w_ub;
    logic   w_exc_a, w_exc_b;

    fpalu_unpack u_unpack_a (.i_word(a), .o_op(w_ua), .o_exc(w_exc_a));
    fpalu_unpack u_unpack_b (.i_word(b), .o_op(w_ub), .o_exc(w_exc_b));

    state_t           r_state;
    logic             r_sa, r_sb, r_sr, r_exc;
    logic [EXP_W-1:0] r_ea, r_eb, r_er;
    logic [MW-1:0]    r_ma, r_mb;
    logic [MW:0]      r_mr;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_result;

    logic [MW:0]      w_sum, w_dab, w_dba;
    logic [EXP_W-1:0] w_er_inc;
    logic             w_cap;

    assign w_sum    = {1'b0, r_ma} + {1'b0, r_mb};
    assign w_dab    = {1'b0, r_ma} - {1'b0, r_mb};
    assign w_dba    = {1'b0, r_mb} - {1'b0, r_ma};
    assign w_er_inc = r_er + 1'b1;
    // Cap fires on the step that would bring the counter to MAX_ALIGN.
    assign w_cap    = (r_cnt == CNT_W'(MAX_ALIGN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_sr     <= 1'b0;
            r_exc    <= 1'b0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_er     <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_mr     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sa  <= w_ua.sign;
                    r_sb  <= w_ub.sign ^ sub;
                    r_ea  <= w_ua.exp;
                    r_eb  <= w_ub.exp;
                    r_ma  <= w_ua.mant;
                    r_mb  <= w_ub.mant;
                    r_cnt <= '0;
                    r_exc <= 1'b0;
                    if (w_exc_a || w_exc_b) begin
                        r_exc    <= 1'b1;
                        r_result <= QNAN;
                        r_state  <= DONE;
                    end else begin
                        r_state  <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (r_ea == r_eb) begin
                        r_state <= ADD;
                    end else if (r_ea < r_eb) begin
                        if (w_cap) begin
                            r_ma    <= '0;
                            r_ea    <= r_eb;
                            r_state <= ADD;
                        end else begin
                            r_ma <= r_ma >> 1;
                            r_ea <= r_ea + 1'b1;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        if (w_cap) begin
                            r_mb    <= '0;
                            r_eb    <= r_ea;
                            r_state <= ADD;
                        end else begin
                            r_mb <= r_mb >> 1;
                            r_eb <= r_eb + 1'b1;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ADD: begin
                    r_er    <= r_ea;
                    r_state <= NORM;
                    if (r_sa == r_sb) begin
                        r_mr <= w_sum;
                        r_sr <= r_sa;
                    end else if (r_ma > r_mb) begin
                        r_mr <= w_dab;
                        r_sr <= r_sa;
                    end else if (r_mb > r_ma) begin
                        r_mr <= w_dba;
                        r_sr <= r_sb;
                    end else begin
                        r_mr <= '0;
                        r_sr <= 1'b0;
                    end
                end
                NORM: begin
                    if (r_mr == '0) begin
                        r_result <= '0;
                        r_state  <= DONE;
                    end else if (r_mr[MW]) begin
                        r_mr <= r_mr >> 1;
                        r_er <= w_er_inc;
                        if (w_er_inc == EXP_MAX) begin
                            r_result <= {r_sr, EXP_MAX, {MAN_W{1'b0}}};
                            r_state  <= DONE;
                        end
                    end else if (!r_mr[MAN_W]) begin
                        // One more left shift would take the exponent to 0: flush.
                        if (r_er == EXP_W'(1)) begin
                            r_result <= {r_sr, 31'b0};
                            r_state  <= DONE;
                        end else begin
                            r_mr <= r_mr << 1;
                            r_er <= r_er - 1'b1;
                        end
                    end else begin
                        r_result <= {r_sr, r_er, r_mr[MAN_W-1:0]};
                        r_state  <= DONE;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign exc       = r_exc;
endmodule

// File: tb/tb_fpadd_seq_ctrl.sv
// Directed bench for fpadd_seq_ctrl with an arithmetic reference model and per-cycle output checks.
module tb_fpadd_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, exc, busy;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_r = '0;
    logic        exp_e = 1'b0;

    fpadd_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .exc(exc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Reference: align by exponent difference, signed integer add, then normalize
    // one position per cycle; lat = edges from accept to out_valid.
    function automatic void model(input logic [31:0] fa, input logic [31:0] fb, input logic fs,
                                  output logic [31:0] r, output logic e, output int lat);
        int ea, eb, ex, d;
        longint ma, mb, v, m;
        logic rs;
        ea = int'(fa[30:23]);
        eb = int'(fb[30:23]);
        r = '0;
        if (ea == 255 || eb == 255) begin
            r = 32'h7FC00000; e = 1'b1; lat = 0;
            return;
        end
        e = 1'b0;
        ma = (ea == 0) ? 0 : longint'(fa[22:0]) + (longint'(1) << 23);
        mb = (eb == 0) ? 0 : longint'(fb[22:0]) + (longint'(1) << 23);
        d  = (ea > eb) ? ea - eb : eb - ea;
        ex = (ea > eb) ? ea : eb;
        if (ea < eb) ma = (d >= 24) ? 0 : (ma >> d);
        else if (eb < ea) mb = (d >= 24) ? 0 : (mb >> d);
        lat = (d == 0) ? 1 : ((d < 24) ? d + 1 : 24);
        lat += 1;
        v  = (fa[31] ? -ma : ma) + ((fb[31] ^ fs) ? -mb : mb);
        rs = (v < 0);
        m  = rs ? -v : v;
        while (1) begin
            lat++;
            if (m == 0) begin
                r = 32'h0; break;
            end
            if (m >= (longint'(1) << 24)) begin
                m = m >> 1; ex++;
                if (ex == 255) begin
                    r = {rs, 8'hFF, 23'h0}; break;
                end
                continue;
            end
            if (m < (longint'(1) << 23)) begin
                if (ex == 1) begin
                    r = {rs, 31'h0}; break;
                end
                m = m << 1; ex--;
                continue;
            end
            r = {rs, 8'(ex), 23'(m)};
            break;
        end
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                          input logic [31:0] lit, input int hold, input bit early);
        logic [31:0] mr;
        logic        me;
        int          mlat, lat;
        model(ta, tb_, ts, mr, me, mlat);
        chk("model_pin", mr, lit);
        @(negedge clk);
        chk("idle_ready", {31'b0, in_ready}, 32'd1);
        exp_r = mr; exp_e = me;
        a = ta; b = tb_; sub = ts; in_valid = 1'b1; out_ready = early;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 32'(lat), 32'(mlat));
        chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
        chk("result_lit", result, lit);
        if (!early) begin
            repeat (hold) begin
                @(negedge clk);
                chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            end
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("ret_out_valid", {31'b0, out_valid}, 32'd0);
        chk("ret_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_vs_ready", {31'b0, busy}, {31'b0, ~in_ready});
            if (out_valid) begin
                chk("cmp_result", result, exp_r);
                chk("cmp_exc", {31'b0, exc}, {31'b0, exp_e});
                chk("cmp_in_ready", {31'b0, in_ready}, 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_exc", {31'b0, exc}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;

        run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 0, 1'b0);
        run_op(32'h40400000, 32'h40200000, 1'b1, 32'h3F000000, 2, 1'b0);
        run_op(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 0, 1'b0);
        run_op(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1, 1'b0);
        run_op(32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 0, 1'b0);
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 0, 1'b1);
        run_op(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 0, 1'b0);
        run_op(32'h80000000, 32'h3F800000, 1'b0, 32'h3F800000, 0, 1'b0);
        run_op(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 0, 1'b1);
        run_op(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 0, 1'b0);
        run_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5, 1'b0);

        // Abort an operation partway through alignment.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h30800000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("abort_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpadd_seq_ctrl.md
Name: fpadd_seq_ctrl

Overview:
Multi-cycle sequencer for the fpalu3 single-precision add/subtract path. It wraps exponent compare/align, mantissa add/subtract, normalize and pack behind a valid/ready handshake.
- Alignment and normalization run iteratively, one bit-shift per cycle, so one small shifter is reused.
- Sits between the operand source and the result consumer. One operation is in flight at a time.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width (hidden bit excluded)
MAX_ALIGN, MAN_W+1, alignment shift cap; beyond this the smaller operand contributes zero

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands presented
in_ready  out  1  block can accept (IDLE only)
a  in  32  operand A, IEEE-754 single
b  in  32  operand B, IEEE-754 single
sub  in  1  1 = A-B (B sign inverted at capture), 0 = A+B
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  32  packed IEEE-754 result, held while out_valid
exc  out  1  exceptional input (exp all-ones) seen; valid with out_valid
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release):
  - State=IDLE.
  - in_ready=1, out_valid=0, result=0, exc=0, busy=0.
  - Internal mantissa and exponent registers are cleared.
- Reset asserted mid-operation aborts immediately. No result is produced.
- States: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture signs (B sign ^ sub), exponents, and mantissas with hidden bit (24b; hidden=0 and mantissa forced 0 when exp==0, i.e. denormals flush to zero).
  - Clear the shift counter. Go to ALIGN.
- Capture with either exponent==255:
  - exc=1; result=0x7FC00000.
  - Go directly to DONE; skip arithmetic.
- ALIGN, one cycle per step:
  - If exponents are equal, go to ADD.
  - Otherwise shift the smaller-exponent mantissa right 1, increment its exponent and increment the counter.
  - If the counter reaches MAX_ALIGN, zero that mantissa, set its exponent equal to the larger one, and go to ADD.
  - ALIGN always lasts at least 1 cycle.
- ADD, exactly 1 cycle, 25-bit signed-magnitude:
  - Equal signs: sum, sign=A sign.
  - Differing signs: larger magnitude minus smaller, sign of the larger.
  - Equal magnitudes: result +0 (sign 0).
  - Go to NORM.
- NORM, one step per cycle:
  - Mantissa==0: result=+0, go to DONE.
  - bit24 set: shift right 1, exp+1 (once).
  - bit23 clear: shift left 1, exp-1.
  - bit23 set and bit24 clear: pack and go to DONE.
  - Exponent reaching 0 during left shifts: flush to signed zero.
  - Exponent reaching 255 after the carry shift: result = signed infinity, mantissa 0.
  - Rounding is truncation (round toward zero); shifted-out bits are discarded.
- DONE:
  - out_valid=1; result and exc stable.
  - On out_ready, go to IDLE next cycle with out_valid=0.
  - out_ready may be held high in advance: DONE still lasts ≥1 cycle.
- in_ready=0 outside IDLE. No input is accepted while busy.
- Latency from the accept edge to out_valid = 1 (ALIGN min) + align steps + 1 (ADD) + norm steps + 1.
  - Equal exponents with carry: 4 cycles.
- Signed zero inputs are handled as mantissa 0 with no exception.

Decomposition:
- Shared package fpalu_pkg holds:
  - EXP_W, MAN_W and EXP_BIAS=127
  - QNAN=32'h7FC00000 and EXP_MAX=255
  - the state enum (IDLE/ALIGN/ADD/NORM/DONE)
  - an unpacked-operand struct {sign, exp, mant24}
- One combinational sub-module, fpalu_unpack: splits a 32b word into that struct, applying hidden bit and denormal flush, with an exc flag.
- The FSM, shifter and adder live in fpadd_seq_ctrl.

Test Plan:
- a=0x3F800000, b=0x3F800000, sub=0 -> result=0x40000000, exc=0, out_valid exactly 4 cycles after accept.
- a=0x40400000 (3.0), b=0x40200000 (2.5), sub=1 -> result=0x3F000000 after two NORM left shifts.
- a=0x3FC00000, b=0x3FC00000, sub=1 -> result=0x00000000.
- a=0x3F800000, b=0x30800000 (2^-30), sub=0 -> alignment caps at 24 steps, result=0x3F800000.
- a=0x7F800000, b=0x3F800000 -> exc=1, result=0x7FC00000, no ALIGN cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; then assert rst_n low mid-ALIGN on the next op -> out_valid=0, in_ready=1 immediately.
